// File: rtl/clkmeas_pkg.sv
// Shared types and configuration helpers for the clkmeas frequency/period meter.
// Optional period measurement is enabled by defining CLKMEAS_PERIOD_EN.
package clkmeas_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COUNT  = 2'd2
    } state_e;

    function automatic int unsigned calc_window(input int unsigned main_hz, input int unsigned gate_hz);
        return (gate_hz == 0) ? 0 : main_hz / gate_hz;
    endfunction

    // Gate window must divide evenly and span at least two cycles; synchroniser needs >= 2 flops.
    function automatic bit cfg_ok(input int unsigned main_hz, input int unsigned gate_hz,
                                  input int unsigned stages);
        return (gate_hz != 0) && ((main_hz % gate_hz) == 0) &&
               (calc_window(main_hz, gate_hz) >= 2) && (stages >= 2);
    endfunction

endpackage

// File: rtl/clkmeas_sigsync.sv
// Synchronises an asynchronous input into in_clk and flags its rising edges.
// Latency: SYNC_STAGES cycles to out_sync, out_rise is combinational from registered state.
// Backpressure: none, free-running.
module clkmeas_sigsync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic in_clk,
    input  logic in_rst,
    input  logic in_sig,
    output logic out_sync,
    output logic out_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_sig};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign out_sync = sync_q[SYNC_STAGES-1];
    assign out_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/clkmeas.sv
// Gated edge counter reporting in_sig frequency in Hz (and edge-to-edge period with CLKMEAS_PERIOD_EN).
// Latency: results and out_valid register one cycle after the terminal gate cycle.
// Backpressure: none; out_valid is a single-cycle strobe, outputs hold between strobes.
module clkmeas
    import clkmeas_pkg::*;
#(
    parameter int unsigned MAIN_CLK_HZ = 50_000_000,
    parameter int unsigned GATE_HZ     = 10,
    parameter int          CTR_BITS    = 32,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                in_clk,
    input  logic                in_rst,
    input  logic                in_en,
    input  logic                in_sig,
    output logic [CTR_BITS-1:0] out_hz,
    output logic [CTR_BITS-1:0] out_edges,
    output logic [CTR_BITS-1:0] out_period,
    output logic                out_ovf,
    output logic                out_valid
);

    localparam int unsigned WINDOW = calc_window(MAIN_CLK_HZ, GATE_HZ);
    localparam int          GATE_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int          SET_W  = $clog2(SYNC_STAGES + 1);

    localparam logic [GATE_W-1:0]   GATE_LAST = GATE_W'(WINDOW - 1);
    localparam logic [SET_W-1:0]    SET_LAST  = SET_W'(SYNC_STAGES);
    localparam logic [CTR_BITS-1:0] GATE_K    = CTR_BITS'(GATE_HZ);
    localparam logic [CTR_BITS-1:0] CTR_ONE   = CTR_BITS'(1);

    if (!cfg_ok(MAIN_CLK_HZ, GATE_HZ, SYNC_STAGES)) begin : g_bad_cfg
        $error("clkmeas: MAIN_CLK_HZ/GATE_HZ must be exact and >= 2, SYNC_STAGES >= 2");
    end

    logic sig_sync;
    logic sig_rise_raw;
    logic sig_rise;

    clkmeas_sigsync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sigsync (
        .in_clk  (in_clk),
        .in_rst  (in_rst),
        .in_sig  (in_sig),
        .out_sync(sig_sync),
        .out_rise(sig_rise_raw)
    );

    assign sig_rise = sig_rise_raw & sig_sync;

    state_e              state_q, state_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic [CTR_BITS-1:0] edge_q, edge_d;
    logic [CTR_BITS-1:0] hz_q, hz_d;
    logic [CTR_BITS-1:0] edges_q, edges_d;
    logic                ovf_q, ovf_d;
    logic                valid_q, valid_d;
    logic [CTR_BITS-1:0] edge_fin;

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q  <= IDLE;
            settle_q <= '0;
            gate_q   <= '0;
            edge_q   <= '0;
            hz_q     <= '0;
            edges_q  <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            gate_q   <= gate_d;
            edge_q   <= edge_d;
            hz_q     <= hz_d;
            edges_q  <= edges_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        gate_d   = gate_q;
        edge_d   = edge_q;
        hz_d     = hz_q;
        edges_d  = edges_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        // Edge arriving in the terminal cycle still belongs to this window.
        edge_fin = (sig_rise && (edge_q != '1)) ? edge_q + CTR_ONE : edge_q;

        case (state_q)
            IDLE: begin
                if (in_en) begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end
            end
            SETTLE: begin
                if (!in_en) begin
                    state_d = IDLE;
                end else if (settle_q == SET_LAST) begin
                    state_d = COUNT;
                    gate_d  = '0;
                    edge_d  = '0;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            COUNT: begin
                if (!in_en) begin
                    state_d = IDLE;
                    gate_d  = '0;
                    edge_d  = '0;
                end else if (gate_q == GATE_LAST) begin
                    edges_d = edge_fin;
                    hz_d    = edge_fin * GATE_K;
                    ovf_d   = (edge_fin == '1);
                    valid_d = 1'b1;
                    gate_d  = '0;
                    edge_d  = '0;
                end else begin
                    gate_d = gate_q + GATE_W'(1);
                    edge_d = edge_fin;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_hz    = hz_q;
    assign out_edges = edges_q;
    assign out_ovf   = ovf_q;
    assign out_valid = valid_q;

`ifdef CLKMEAS_PERIOD_EN
    logic [CTR_BITS-1:0] per_ctr_q, per_ctr_d;
    logic [CTR_BITS-1:0] period_q, period_d;
    logic                per_arm_q, per_arm_d;

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            per_ctr_q <= '0;
            period_q  <= '0;
            per_arm_q <= 1'b0;
        end else begin
            per_ctr_q <= per_ctr_d;
            period_q  <= period_d;
            per_arm_q <= per_arm_d;
        end
    end

    // First edge after entering COUNT only arms the counter; later edges report edge-to-edge spacing.
    always_comb begin
        per_ctr_d = per_ctr_q;
        period_d  = period_q;
        per_arm_d = per_arm_q;
        if (state_q != COUNT) begin
            per_ctr_d = '0;
            per_arm_d = 1'b0;
        end else if (sig_rise) begin
            if (per_arm_q) begin
                period_d = (per_ctr_q == '1) ? '1 : per_ctr_q + CTR_ONE;
            end
            per_ctr_d = '0;
            per_arm_d = 1'b1;
        end else if (per_ctr_q != '1) begin
            per_ctr_d = per_ctr_q + CTR_ONE;
        end
    end

    assign out_period = period_q;
`else
    assign out_period = '0;
`endif

endmodule

// File: tb/tb_clkmeas.sv
// Directed bench for clkmeas: two instances (32-bit and 6-bit counters), WINDOW = 1000 cycles.
module tb_clkmeas;
    import clkmeas_pkg::*;

`ifdef CLKMEAS_PERIOD_EN
    localparam bit PER = 1'b1;
`else
    localparam bit PER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;
    logic        man_a = 1'b0;
    int          gen_per_a = 0;
    int          gen_per_b = 0;
    int          gen_cnt_a = 0;
    int          gen_cnt_b = 0;
    logic        gen_sig_a = 1'b0;
    logic        gen_sig_b = 1'b0;
    logic        sig_a;
    logic        sig_b;

    logic [31:0] a_hz, a_edges, a_period;
    logic        a_ovf, a_valid;
    logic [5:0]  b_hz, b_edges, b_period;
    logic        b_ovf, b_valid;

    int n_cmp = 0;
    int n_bad = 0;

    assign sig_a = (gen_per_a != 0) ? gen_sig_a : man_a;
    assign sig_b = gen_sig_b;

    clkmeas #(.MAIN_CLK_HZ(1_000_000), .GATE_HZ(1000), .CTR_BITS(32), .SYNC_STAGES(2)) u_a (
        .in_clk(clk), .in_rst(rst_n), .in_en(en_a), .in_sig(sig_a),
        .out_hz(a_hz), .out_edges(a_edges), .out_period(a_period),
        .out_ovf(a_ovf), .out_valid(a_valid)
    );

    clkmeas #(.MAIN_CLK_HZ(1_000_000), .GATE_HZ(1000), .CTR_BITS(6), .SYNC_STAGES(2)) u_b (
        .in_clk(clk), .in_rst(rst_n), .in_en(en_b), .in_sig(sig_b),
        .out_hz(b_hz), .out_edges(b_edges), .out_period(b_period),
        .out_ovf(b_ovf), .out_valid(b_valid)
    );

    always #5 clk = ~clk;

    // Square-wave sources: high for the first half of each period.
    always @(negedge clk) begin
        if (gen_per_a == 0) begin
            gen_cnt_a = 0;
            gen_sig_a = 1'b0;
        end else begin
            gen_sig_a = (gen_cnt_a < gen_per_a / 2);
            gen_cnt_a = (gen_cnt_a + 1 >= gen_per_a) ? 0 : gen_cnt_a + 1;
        end
        if (gen_per_b == 0) begin
            gen_cnt_b = 0;
            gen_sig_b = 1'b0;
        end else begin
            gen_sig_b = (gen_cnt_b < gen_per_b / 2);
            gen_cnt_b = (gen_cnt_b + 1 >= gen_per_b) ? 0 : gen_cnt_b + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input bit use_b, input int bound, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(use_b ? b_valid : a_valid) && waited < bound);
        n_cmp++;
        assert (use_b ? b_valid : a_valid) else begin
            n_bad++;
            $error("FAIL %s_valid_timeout: observed no strobe in %0d cycles, expected one", use_b ? "b" : "a", bound);
        end
    endtask

    initial begin
        int  w;
        bit  seen;

        // Reset state
        step(3);
        chk("rst_hz", a_hz, 0);
        chk("rst_edges", a_edges, 0);
        chk("rst_period", a_period, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_state", u_a.state_q, IDLE);
        rst_n = 1'b1;
        step(2);

        // Constant low input: zero edges, strobe still fires, latency 3 + 1000 + 1
        en_a = 1'b1;
        wait_valid(0, 1100, w);
        chk("t2_latency", w, 1004);
        chk("t2_edges", a_edges, 0);
        chk("t2_hz", a_hz, 0);
        chk("t2_ovf", a_ovf, 0);
        chk("t2_period", a_period, 0);
        step(1);
        chk("t2_strobe_width", a_valid, 0);

        // Period-10 input: 100 edges per window
        gen_per_a = 10;
        wait_valid(0, 1100, w);
        wait_valid(0, 1100, w);
        chk("t1_edges", a_edges, 100);
        chk("t1_hz", a_hz, 100_000);
        chk("t1_ovf", a_ovf, 0);
        chk("t1_period", a_period, PER ? 10 : 0);
        wait_valid(0, 1100, w);
        chk("t1_spacing", w, 1000);
        chk("t1_edges2", a_edges, 100);

        // Asynchronous reset mid-window
        step(300);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_hz", a_hz, 0);
        chk("t6_edges", a_edges, 0);
        chk("t6_period", a_period, 0);
        chk("t6_valid", a_valid, 0);
        en_a = 1'b0;
        step(2);
        rst_n = 1'b1;
        gen_per_a = 0;
        step(5);
        chk("t6_idle", u_a.state_q, IDLE);
        chk("t6_valid_after", a_valid, 0);

        // Edge in terminal gate cycle vs. first cycle of next window
        en_a = 1'b1;
        step(1001);
        man_a = 1'b1;
        step(2);
        chk("t4_pre_strobe", a_valid, 0);
        step(1);
        chk("t4_w1_valid", a_valid, 1);
        chk("t4_w1_edges", a_edges, 1);
        chk("t4_w1_hz", a_hz, 1000);
        chk("t4_first_edge_period", a_period, 0);
        step(496);
        man_a = 1'b0;
        step(502);
        man_a = 1'b1;
        step(2);
        chk("t4_w2_valid", a_valid, 1);
        chk("t4_w2_edges", a_edges, 0);
        step(1000);
        chk("t4_w3_valid", a_valid, 1);
        chk("t4_w3_edges", a_edges, 1);
        chk("t4_period", a_period, PER ? 1001 : 0);

        // Enable dropped at gate_ctr = 500
        man_a = 1'b0;
        en_a = 1'b0;
        step(3);
        en_a = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 504; i++) begin
            step(1);
            seen |= a_valid;
        end
        en_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            seen |= a_valid;
        end
        chk("t5_no_strobe", seen, 0);
        chk("t5_idle", u_a.state_q, IDLE);
        chk("t5_hold_edges", a_edges, 1);
        chk("t5_hold_hz", a_hz, 1000);
        en_a = 1'b1;
        step(1003);
        chk("t5_pre_strobe", a_valid, 0);
        step(1);
        chk("t5_valid", a_valid, 1);
        chk("t5_edges", a_edges, 0);
        en_a = 1'b0;

        // 6-bit counters: saturation and truncated Hz, then recovery
        gen_per_b = 4;
        step(8);
        en_b = 1'b1;
        wait_valid(1, 1100, w);
        chk("t3_latency", w, 1004);
        chk("t3_sat_edges", b_edges, 63);
        chk("t3_sat_ovf", b_ovf, 1);
        chk("t3_sat_hz", b_hz, 24);
        chk("t3_period4", b_period, PER ? 4 : 0);
        gen_per_b = 100;
        wait_valid(1, 1100, w);
        wait_valid(1, 1100, w);
        chk("t3_edges", b_edges, 10);
        chk("t3_ovf", b_ovf, 0);
        chk("t3_hz", b_hz, 16);
        chk("t3_period_sat", b_period, PER ? 63 : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
